// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package addsub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_fa.sv
// One-bit full adder: the only arithmetic element of the serial datapath.
module fullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Sum and carry of a single bit slice.
  always_comb begin
    o_sum  = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: LSB first, one bit per clock through one
// full-adder cell. Subtraction is A + ~B + 1 (operand inverted on load,
// carry flop preset to 1).
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic             carry_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_bit;
  logic             cout_bit;

  fullAdder u_fa (
    .i_a    (a_q[0]),
    .i_b    (b_q[0]),
    .i_cin  (c_q),
    .o_sum  (sum_bit),
    .o_cout (cout_bit)
  );

  // Control FSM and serial datapath registers; all outputs are registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b ^ {WIDTH{i_sub}};
            c_q     <= i_sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q <= {sum_bit, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= cout_bit;
          if (cnt_q == LAST) begin
            // c_q here is the carry into the MSB slice.
            carry_q <= cout_bit;
            ovf_q   <= c_q ^ cout_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive ports straight from the registers.
  always_comb begin
    o_busy     = busy_q;
    o_done     = done_q;
    o_result   = res_q;
    o_carry    = carry_q;
    o_overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8) against an
// arithmetic reference model.
module tb_serial_addsub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  int last_r = 0;
  bit last_c = 1'b0;
  bit last_v = 1'b0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_sub      (sub),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_carry    (carry),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_model(input int ua, input int ub, input bit s,
                                    output int r, output bit c, output bit v);
    int sa, sb, sr;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (s) begin
      r  = (ua - ub + 256) % 256;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = (ua + ub) % 256;
      c  = ((ua + ub) > 255);
      sr = sa + sb;
    end
    v = (sr > 127) || (sr < -128);
  endfunction

  // One operation: accept, then exactly W edges to o_done. Optionally pulse
  // i_start with junk operands at RUN edge 'glitch', or keep i_start high
  // into DONE so the caller's next operation starts back-to-back.
  task automatic run_op(input int ua, input int ub, input bit s,
                        input int glitch, input bit hold, input string tag);
    int r;
    bit c, v;
    ref_model(ua, ub, s, r, c, v);
    @(negedge clk);
    start = 1'b1;
    a     = ua[W-1:0];
    b     = ub[W-1:0];
    sub   = s;
    @(posedge clk);
    #1;
    check({tag, ".busy_acc"}, 32'(busy), 32'd1);
    check({tag, ".done_acc"}, 32'(done), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = ~s;
      if (e == glitch) start = 1'b1;
      else if (hold && e == 8) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      #1;
      if (e < 8) begin
        check({tag, ".done_run"}, 32'(done), 32'd0);
        check({tag, ".busy_run"}, 32'(busy), 32'd1);
      end else begin
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), 32'(r));
        check({tag, ".carry"}, 32'(carry), 32'(c));
        check({tag, ".ovf"}, 32'(ovf), 32'(v));
      end
    end
    last_r = r;
    last_c = c;
    last_v = v;
  endtask

  // Idle cycles: no pulse, results held.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      @(posedge clk);
      #1;
      check("idle.done", 32'(done), 32'd0);
      check("idle.busy", 32'(busy), 32'd0);
      check("idle.result", 32'(result), 32'(last_r));
      check("idle.carry", 32'(carry), 32'(last_c));
      check("idle.ovf", 32'(ovf), 32'(last_v));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.carry", 32'(carry), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Start lands on the first rising edge after release.
    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, "add_05_03");
    idle_cycles(2);
    run_op(8'h03, 8'h05, 1'b1, 0, 1'b0, "sub_03_05");
    idle_cycles(1);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, "add_7f_01");
    idle_cycles(1);
    run_op(8'h80, 8'h01, 1'b1, 0, 1'b0, "sub_80_01");
    idle_cycles(1);
    run_op(8'h12, 8'h34, 1'b0, 3, 1'b0, "ignore_start");
    idle_cycles(1);
    run_op(8'hA0, 8'h0F, 1'b1, 0, 1'b1, "b2b_first");
    run_op(8'h55, 8'hAA, 1'b0, 0, 1'b0, "b2b_second");
    idle_cycles(1);

    // Abort mid-RUN at bit 4.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h3C;
    b     = 8'h4B;
    sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.carry", 32'(carry), 32'd0);
    check("abort.ovf", 32'(ovf), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort.hold_done", 32'(done), 32'd0);
      check("abort.hold_busy", 32'(busy), 32'd0);
    end
    rst_n  = 1'b1;
    last_r = 0;
    last_c = 1'b0;
    last_v = 1'b0;
    idle_cycles(1);
    run_op(8'hC8, 8'h64, 1'b1, 0, 1'b0, "after_abort");

    // Random sweep with occasional ignored pulses and back-to-back starts.
    for (int n = 0; n < 1000; n++) begin
      int g;
      bit h;
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      h = ($urandom_range(0, 3) == 0);
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             bit'($urandom_range(0, 1)), g, h, "rand");
      if (!h) idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits (legal values 2..32).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_start, input, 1 bit: request to begin an operation.
REQ-005 SHALL have port i_sub, input, 1 bit: operation select, 0 = A+B, 1 = A-B; sampled with i_start.
REQ-006 SHALL have port i_a, input, WIDTH bits: operand A; sampled with i_start.
REQ-007 SHALL have port i_b, input, WIDTH bits: operand B; sampled with i_start.
REQ-008 SHALL have port o_busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port o_done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 SHALL have port o_result, output, WIDTH bits: sum or difference, modulo 2^WIDTH.
REQ-011 SHALL have port o_carry, output, 1 bit: carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 SHALL have port o_overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 SHALL compute bit-serially, LSB first, one bit per clock, through a single full-adder cell.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept i_start only in IDLE or DONE.
REQ-016 SHALL, on accept, load A and (B XOR {WIDTH{i_sub}}) into shift registers, set the carry flop to i_sub, clear the bit counter and enter RUN.
REQ-017 SHALL ignore i_start while in RUN, with no effect on operands or timing.
REQ-018 SHALL, on each RUN edge, add bit 0 of each operand register plus the carry flop, shift the sum bit into the result register from the MSB end, shift both operand registers right by 1, register the carry out, and increment the counter.
REQ-019 SHALL, on the RUN edge where counter = WIDTH-1, register o_carry and o_overflow and enter DONE.
REQ-020 SHALL compute o_overflow as (carry into MSB) XOR (carry out of MSB).
REQ-021 SHALL assert o_done for exactly the one cycle in DONE, starting WIDTH edges after the accepting edge; total latency is WIDTH+1 cycles from start to result.
REQ-022 SHALL go from DONE to IDLE on the next edge, or to RUN if i_start is high (back-to-back, no bubble).
REQ-023 SHALL hold o_result, o_carry and o_overflow from DONE until the next accepted start.
REQ-024 SHALL update o_result only by shifting during RUN; its value is undefined-but-stable while o_busy is high.
REQ-025 SHALL size the bit counter to clog2(WIDTH) bits, with no wrap-around beyond WIDTH-1.

Reset
REQ-026 SHALL, while i_rst_n is low, force: state IDLE; o_busy 0; o_done 0; o_result 0; o_carry 0; o_overflow 0; counter 0; carry flop 0; operand registers 0.
REQ-027 SHALL abort an operation in progress when reset is asserted mid-RUN, with no o_done pulse for that operation.
REQ-028 SHALL accept a start on the first rising edge after i_rst_n deasserts.

Structure
REQ-029 SHALL take the state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the default WIDTH from the shared package addsub_pkg.
REQ-030 SHALL instantiate exactly one existing fullAdder sub-module as the bit-slice datapath; there SHALL be no other arithmetic operator on the operands.
REQ-031 SHALL place all sequential logic in this module; the sub-module SHALL stay purely combinational.

Verification (WIDTH=8)
REQ-032 Bench SHALL cover: A=0x05, B=0x03, sub=0 -> o_done 8 edges after accept; result 0x08; carry 0; overflow 0.
REQ-033 Bench SHALL cover: 0x03-0x05 -> result 0xFE, carry 0 (borrow), overflow 0; then 0x7F+0x01 -> result 0x80, overflow 1; then 0x80-0x01 -> result 0x7F, overflow 1, carry 1.
REQ-034 Bench SHALL cover: i_start pulsed with different operands 3 cycles into RUN -> ignored; the original result and timing are unchanged.
REQ-035 Bench SHALL cover: i_start held high through DONE -> the second operation starts with no IDLE cycle, and its o_done follows 8 edges later.
REQ-036 Bench SHALL cover: i_rst_n pulled low at RUN bit 4 -> all outputs 0, state IDLE, no o_done; a fresh start after release gives the correct result.
REQ-037 Bench SHALL cover: a random 1000-operation sweep against a reference (A±B) mod 256, checking carry and overflow.
